// File: rtl/sm83_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sm83_irq_arbiter
// Purpose  : SM83-style interrupt controller. Detects rising edges on the
//            request lines into the IF register, qualifies them with IE and
//            the master enable (IME), picks a winner (fixed or round-robin),
//            and runs a short IDLE -> GRANT -> VECTOR dispatch handshake with
//            the instruction sequencer. Also handles HALT and its wake-up.
// Ports    : clk, areset            clock, async active-high reset
//            irq                    request strobes (edge detected)
//            ie_we/ie_din           IE register write
//            if_we/if_din           IF register write
//            ime_set/_dly/_clr      RETI / EI / DI
//            boundary, vec_taken    sequencer handshake
//            halt_req               HALT instruction pulse
//            ie_q, if_q, ime_q      register contents
//            int_pending            dispatch wanted at next boundary
//            vec_valid, vector      dispatch target
//            iack                   one-hot acknowledge pulse
//            halted, wake           halt state, one-cycle wake pulse
// Revision : 1.0  initial release
// ============================================================================
module sm83_irq_arbiter #(
  parameter int NUM_IRQS   = 5,
  parameter int ADR_WIDTH  = 16,
  parameter int VEC_BASE   = 'h0040,
  parameter int VEC_STRIDE = 8,
  parameter int RR_MODE    = 0
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [NUM_IRQS-1:0]  irq,
  input  logic                 ie_we,
  input  logic [NUM_IRQS-1:0]  ie_din,
  input  logic                 if_we,
  input  logic [NUM_IRQS-1:0]  if_din,
  input  logic                 ime_set,
  input  logic                 ime_set_dly,
  input  logic                 ime_clr,
  input  logic                 boundary,
  input  logic                 vec_taken,
  input  logic                 halt_req,
  output logic [NUM_IRQS-1:0]  ie_q,
  output logic [NUM_IRQS-1:0]  if_q,
  output logic                 ime_q,
  output logic                 int_pending,
  output logic                 vec_valid,
  output logic [ADR_WIDTH-1:0] vector,
  output logic [NUM_IRQS-1:0]  iack,
  output logic                 halted,
  output logic                 wake
);

  localparam int IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_VECTOR = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_IRQS-1:0]    irq_prev_q;
  logic [NUM_IRQS-1:0]    ie_d, if_d;
  logic                   ime_d;
  logic                   ei_pend_q, ei_pend_d;
  logic                   ei_cnt_q, ei_cnt_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic                   vec_valid_q, vec_valid_d;
  logic [ADR_WIDTH-1:0]   vector_q, vector_d;
  logic [NUM_IRQS-1:0]    iack_q, iack_d;
  logic                   halted_q, halted_d;
  logic                   wake_q, wake_d;

  logic [NUM_IRQS-1:0]    hw_set, if_sel, clr_mask, active, win_oh;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_found, grant_now, still_active;

  assign hw_set      = irq & ~irq_prev_q;
  assign active      = ie_q & if_q;
  assign int_pending = ime_q && (|active) && (state_q == ST_IDLE);

  assign vec_valid = vec_valid_q;
  assign vector    = vector_q;
  assign iack      = iack_q;
  assign halted    = halted_q;
  assign wake      = wake_q;

  // Winner search: scan from the start index, wrapping. Fixed mode always
  // starts at 0, which degenerates to lowest-set-bit priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      int idx;
      idx = ((RR_MODE != 0) ? int'(rr_ptr_q) : 0) + i;
      if (idx >= NUM_IRQS) idx = idx - NUM_IRQS;
      if (!win_found && active[idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IRQS; i++) begin
      win_oh[i] = (winner_q == IDX_W'(i));
    end
  end

  always_comb begin
    ie_d        = ie_we ? ie_din : ie_q;
    if_sel      = if_we ? if_din : if_q;
    clr_mask    = '0;
    state_d     = state_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    vec_valid_d = vec_valid_q;
    vector_d    = vector_q;
    iack_d      = '0;
    grant_now   = 1'b0;
    // The cancel check looks at the enable/flag values that will be in
    // effect after this edge, so a register write in the GRANT cycle counts.
    still_active = |(win_oh & ie_d & (if_sel | hw_set));

    case (state_q)
      ST_IDLE: begin
        if (boundary && int_pending && win_found) begin
          state_d   = ST_GRANT;
          winner_d  = win_idx;
          grant_now = 1'b1;
        end
      end
      ST_GRANT: begin
        state_d     = ST_VECTOR;
        vec_valid_d = 1'b1;
        if (still_active) begin
          iack_d   = win_oh;
          clr_mask = win_oh;
          vector_d = ADR_WIDTH'(VEC_BASE)
                   + ADR_WIDTH'(winner_q) * ADR_WIDTH'(VEC_STRIDE);
          rr_ptr_d = (int'(winner_q) == NUM_IRQS - 1) ? '0
                                                      : winner_q + IDX_W'(1);
        end else begin
          vector_d = '0;
        end
      end
      ST_VECTOR: begin
        if (vec_taken) begin
          state_d     = ST_IDLE;
          vec_valid_d = 1'b0;
          vector_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A hardware edge beats both the register write and the acknowledge clear.
    if_d = (if_sel & ~clr_mask) | hw_set;

    // EI takes effect on the second boundary after it, so the instruction
    // following EI completes before interrupts are accepted.
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
    ei_cnt_d  = ei_cnt_q;
    if (ei_pend_q && boundary) begin
      if (ei_cnt_q) begin
        ime_d     = 1'b1;
        ei_pend_d = 1'b0;
        ei_cnt_d  = 1'b0;
      end else begin
        ei_cnt_d = 1'b1;
      end
    end
    if (ime_set_dly) begin
      ei_pend_d = 1'b1;
      ei_cnt_d  = 1'b0;
    end
    if (ime_set) ime_d = 1'b1;
    if (grant_now) ime_d = 1'b0;
    if (ime_clr) begin
      ime_d     = 1'b0;
      ei_pend_d = 1'b0;
      ei_cnt_d  = 1'b0;
    end

    // HALT wakes on any enabled flag, independent of IME.
    halted_d = halted_q;
    wake_d   = 1'b0;
    if (halted_q) begin
      if (|active) begin
        halted_d = 1'b0;
        wake_d   = 1'b1;
      end
    end else if (halt_req && !(|active)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      irq_prev_q  <= '0;
      ie_q        <= '0;
      if_q        <= '0;
      ime_q       <= 1'b0;
      ei_pend_q   <= 1'b0;
      ei_cnt_q    <= 1'b0;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      vec_valid_q <= 1'b0;
      vector_q    <= '0;
      iack_q      <= '0;
      halted_q    <= 1'b0;
      wake_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_prev_q  <= irq;
      ie_q        <= ie_d;
      if_q        <= if_d;
      ime_q       <= ime_d;
      ei_pend_q   <= ei_pend_d;
      ei_cnt_q    <= ei_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      vec_valid_q <= vec_valid_d;
      vector_q    <= vector_d;
      iack_q      <= iack_d;
      halted_q    <= halted_d;
      wake_q      <= wake_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm83_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm83_irq_arbiter
// Purpose  : Self-checking bench for sm83_irq_arbiter. Two instances: one in
//            fixed-priority mode, one in round-robin mode. Expected dispatches
//            are queued by the stimulus; per-instance monitors pop and compare
//            on each rising edge of vec_valid. Register/halt state is compared
//            directly against hand-computed constants.
// Revision : 1.0  initial release
// ============================================================================
module tb_sm83_irq_arbiter;

  typedef struct packed {
    logic [15:0] vec;
    logic [4:0]  ack;
  } exp_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Fixed-priority instance
  logic [4:0]  a_irq = '0, a_ie_din = '0, a_if_din = '0;
  logic        a_ie_we = 0, a_if_we = 0, a_ime_set = 0, a_ime_set_dly = 0, a_ime_clr = 0;
  logic        a_boundary = 0, a_vec_taken = 0, a_halt_req = 0;
  logic [4:0]  a_ie_q, a_if_q, a_iack;
  logic        a_ime_q, a_int_pending, a_vec_valid, a_halted, a_wake;
  logic [15:0] a_vector;

  // Round-robin instance
  logic [4:0]  b_irq = '0, b_ie_din = '0, b_if_din = '0;
  logic        b_ie_we = 0, b_if_we = 0, b_ime_set = 0, b_ime_set_dly = 0, b_ime_clr = 0;
  logic        b_boundary = 0, b_vec_taken = 0, b_halt_req = 0;
  logic [4:0]  b_ie_q, b_if_q, b_iack;
  logic        b_ime_q, b_int_pending, b_vec_valid, b_halted, b_wake;
  logic [15:0] b_vector;

  sm83_irq_arbiter #(.NUM_IRQS(5), .ADR_WIDTH(16), .VEC_BASE('h0040),
                     .VEC_STRIDE(8), .RR_MODE(0)) u_fixed (
    .clk(clk), .areset(areset), .irq(a_irq),
    .ie_we(a_ie_we), .ie_din(a_ie_din), .if_we(a_if_we), .if_din(a_if_din),
    .ime_set(a_ime_set), .ime_set_dly(a_ime_set_dly), .ime_clr(a_ime_clr),
    .boundary(a_boundary), .vec_taken(a_vec_taken), .halt_req(a_halt_req),
    .ie_q(a_ie_q), .if_q(a_if_q), .ime_q(a_ime_q), .int_pending(a_int_pending),
    .vec_valid(a_vec_valid), .vector(a_vector), .iack(a_iack),
    .halted(a_halted), .wake(a_wake)
  );

  sm83_irq_arbiter #(.NUM_IRQS(5), .ADR_WIDTH(16), .VEC_BASE('h0040),
                     .VEC_STRIDE(8), .RR_MODE(1)) u_rr (
    .clk(clk), .areset(areset), .irq(b_irq),
    .ie_we(b_ie_we), .ie_din(b_ie_din), .if_we(b_if_we), .if_din(b_if_din),
    .ime_set(b_ime_set), .ime_set_dly(b_ime_set_dly), .ime_clr(b_ime_clr),
    .boundary(b_boundary), .vec_taken(b_vec_taken), .halt_req(b_halt_req),
    .ie_q(b_ie_q), .if_q(b_if_q), .ime_q(b_ime_q), .int_pending(b_int_pending),
    .vec_valid(b_vec_valid), .vector(b_vector), .iack(b_iack),
    .halted(b_halted), .wake(b_wake)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare each new dispatch against the head of the queue.
  logic a_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (areset) a_prev = 1'b0;
    else begin
      if (a_vec_valid && !a_prev) begin
        if (qa.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mon_a_unexpected: got vector 0x%0h, expected no dispatch", a_vector);
        end else begin
          e = qa.pop_front();
          chk("mon_a_vector", 32'(a_vector), 32'(e.vec));
          chk("mon_a_iack", 32'(a_iack), 32'(e.ack));
        end
      end
      a_prev = a_vec_valid;
    end
  end

  logic b_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (areset) b_prev = 1'b0;
    else begin
      if (b_vec_valid && !b_prev) begin
        if (qb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mon_b_unexpected: got vector 0x%0h, expected no dispatch", b_vector);
        end else begin
          e = qb.pop_front();
          chk("mon_b_vector", 32'(b_vector), 32'(e.vec));
          chk("mon_b_iack", 32'(b_iack), 32'(e.ack));
        end
      end
      b_prev = b_vec_valid;
    end
  end

  task automatic a_wait_take();
    int k;
    k = 0;
    while (!a_vec_valid && k < 8) begin tick(); k++; end
    chk("a_vec_valid_timeout", 32'(a_vec_valid), 32'd1);
    a_vec_taken = 1; tick(); a_vec_taken = 0;
    tick();
  endtask

  task automatic a_dispatch();
    a_boundary = 1; tick(); a_boundary = 0;
    a_wait_take();
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ie", 32'(a_ie_q), 0);
    chk("rst_if", 32'(a_if_q), 0);
    chk("rst_ime", 32'(a_ime_q), 0);
    chk("rst_vec_valid", 32'(a_vec_valid), 0);
    chk("rst_vector", 32'(a_vector), 0);
    chk("rst_halted", 32'(a_halted), 0);
    areset = 0;
    tick();

    // Single dispatch of channel 2
    a_ie_we = 1; a_ie_din = 5'h1F; a_ime_set = 1; tick();
    a_ie_we = 0; a_ime_set = 0;
    chk("t1_ie", 32'(a_ie_q), 32'h1F);
    chk("t1_ime", 32'(a_ime_q), 1);
    a_irq = 5'b00100; tick();
    chk("t1_if", 32'(a_if_q), 32'b00100);
    chk("t1_pending", 32'(a_int_pending), 1);
    qa.push_back('{vec: 16'h0050, ack: 5'b00100});
    a_boundary = 1; tick(); a_boundary = 0;
    chk("t1_ime_cleared", 32'(a_ime_q), 0);
    chk("t1_pending_grant", 32'(a_int_pending), 0);
    a_wait_take();
    chk("t1_if_cleared", 32'(a_if_q), 0);
    a_irq = '0;

    // Fixed priority: channel 1 before channel 4
    a_if_we = 1; a_if_din = 5'b10010; a_ime_set = 1; tick();
    a_if_we = 0; a_ime_set = 0;
    qa.push_back('{vec: 16'h0048, ack: 5'b00010});
    qa.push_back('{vec: 16'h0060, ack: 5'b10000});
    a_dispatch();
    chk("t2_if_after1", 32'(a_if_q), 32'b10000);
    a_ime_set = 1; tick(); a_ime_set = 0;
    a_dispatch();
    chk("t2_if_after2", 32'(a_if_q), 0);

    // Cancelled grant: IE bit of the winner cleared during GRANT
    a_ime_set = 1; a_if_we = 1; a_if_din = 5'b01000; tick();
    a_ime_set = 0; a_if_we = 0;
    qa.push_back('{vec: 16'h0000, ack: 5'b00000});
    a_boundary = 1; tick(); a_boundary = 0;
    a_ie_we = 1; a_ie_din = 5'b10111; tick(); a_ie_we = 0;
    chk("t3_if_retained", 32'(a_if_q), 32'b01000);
    chk("t3_iack_none", 32'(a_iack), 0);
    a_wait_take();
    a_if_we = 1; a_if_din = '0; tick(); a_if_we = 0;

    // Delayed EI
    a_ime_set_dly = 1; tick(); a_ime_set_dly = 0;
    chk("t4_ime_after_ei", 32'(a_ime_q), 0);
    a_boundary = 1; tick(); a_boundary = 0;
    chk("t4_ime_after_b1", 32'(a_ime_q), 0);
    a_boundary = 1; tick(); a_boundary = 0;
    chk("t4_ime_after_b2", 32'(a_ime_q), 1);
    a_ime_clr = 1; tick(); a_ime_clr = 0;
    chk("t4_ime_di", 32'(a_ime_q), 0);
    a_ime_set_dly = 1; tick(); a_ime_set_dly = 0;
    a_boundary = 1; tick(); a_boundary = 0;
    a_ime_clr = 1; tick(); a_ime_clr = 0;
    a_boundary = 1; tick(); tick(); a_boundary = 0;
    chk("t4_ime_di_cancels_ei", 32'(a_ime_q), 0);

    // HALT wake with IME=0
    a_halt_req = 1; tick(); a_halt_req = 0;
    chk("t5_halted", 32'(a_halted), 1);
    a_irq = 5'b00001; tick();
    chk("t5_if0", 32'(a_if_q), 32'b00001);
    chk("t5_still_halted", 32'(a_halted), 1);
    chk("t5_no_wake_yet", 32'(a_wake), 0);
    tick();
    chk("t5_unhalted", 32'(a_halted), 0);
    chk("t5_wake", 32'(a_wake), 1);
    tick();
    chk("t5_wake_pulse", 32'(a_wake), 0);
    chk("t5_no_pending", 32'(a_int_pending), 0);

    // HALT while an enabled flag is already set: not entered
    a_halt_req = 1; tick(); a_halt_req = 0;
    chk("t6_not_halted", 32'(a_halted), 0);
    tick();
    chk("t6_no_wake", 32'(a_wake), 0);

    // Reset in the middle of a dispatch
    a_ime_set = 1; tick(); a_ime_set = 0;
    a_boundary = 1; tick(); a_boundary = 0;
    #1 areset = 1; a_irq = '0;
    #1;
    chk("t7_vec_valid", 32'(a_vec_valid), 0);
    chk("t7_iack", 32'(a_iack), 0);
    chk("t7_if", 32'(a_if_q), 0);
    tick();
    areset = 0;
    tick();
    chk("t7_ime", 32'(a_ime_q), 0);

    // Round robin between channels 0 and 3, flags kept pending
    b_ie_we = 1; b_ie_din = 5'h1F; b_if_we = 1; b_if_din = 5'b01001; tick();
    b_ie_we = 0;
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 0) qb.push_back('{vec: 16'h0040, ack: 5'b00001});
      else            qb.push_back('{vec: 16'h0058, ack: 5'b01000});
      b_ime_set = 1; tick(); b_ime_set = 0;
      b_boundary = 1; tick(); b_boundary = 0;
      k = 0;
      while (!b_vec_valid && k < 8) begin tick(); k++; end
      chk("rr_vec_valid_timeout", 32'(b_vec_valid), 1);
      b_vec_taken = 1; tick(); b_vec_taken = 0;
      tick();
    end
    b_if_we = 0;

    tick();
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sm83_irq_arbiter.md
SM83_IRQ_ARBITER -- requirements
Module: sm83_irq_arbiter

Interface
REQ-001 Parameter NUM_IRQS, default 5, number of interrupt channels (1..16).
REQ-002 Parameter ADR_WIDTH, default 16, vector width.
REQ-003 Parameter VEC_BASE, default 'h0040, address of channel 0 vector.
REQ-004 Parameter VEC_STRIDE, default 8, address step between channel vectors (power of two).
REQ-005 Parameter RR_MODE, default 0, priority mode: 0 fixed (lowest index wins), 1 round-robin.
REQ-006 Reset areset is asynchronous and active-high; clock clk.
REQ-007 clk  in  1  system clock, all state on rising edge.
REQ-008 areset  in  1  asynchronous active-high reset.
REQ-009 irq  in  NUM_IRQS  request strobes, rising-edge detected per channel.
REQ-010 ie_we, ie_din  in  1, NUM_IRQS  enable-register write.
REQ-011 if_we, if_din  in  1, NUM_IRQS  flag-register write.
REQ-012 ime_set, ime_set_dly, ime_clr  in  1 each  RETI, EI, DI pulses.
REQ-013 boundary  in  1  instruction-boundary pulse from the sequencer.
REQ-014 vec_taken  in  1  sequencer consumed vector.
REQ-015 halt_req  in  1  HALT instruction pulse.
REQ-016 ie_q, if_q  out  NUM_IRQS  register contents.
REQ-017 ime_q, int_pending  out  1  master enable; dispatch wanted.
REQ-018 vec_valid, vector  out  1, ADR_WIDTH  dispatch target.
REQ-019 iack  out  NUM_IRQS  one-hot acknowledge pulse.
REQ-020 halted, wake  out  1  halt state; one-cycle wake pulse.

Function
REQ-021 Flag bit n SHALL set on a 0->1 transition of irq[n] (registered previous value).
REQ-022 if_we SHALL load if_q from if_din; a same-cycle hardware set of bit n SHALL win over the write and over an iack clear of bit n.
REQ-023 ie_we SHALL load ie_q from ie_din the same cycle.
REQ-024 active = ie_q & if_q; int_pending SHALL equal ime_q && |active && state==IDLE.
REQ-025 ime_clr SHALL clear ime_q and the EI-pending bit immediately; ime_set SHALL set ime_q next cycle; ime_set_dly SHALL set the pending bit, which transfers to ime_q on the second following boundary pulse (one-instruction delay).
REQ-026 State machine IDLE, GRANT, VECTOR.
REQ-027 IDLE -> GRANT when boundary && int_pending: winner index latched, ime_q cleared.
REQ-028 Fixed mode winner = lowest set bit of active; RR mode winner = first set bit of active at or after rr_ptr, wrapping NUM_IRQS-1 -> 0; rr_ptr = winner+1 modulo NUM_IRQS on each non-cancelled grant.
REQ-029 GRANT -> VECTOR after exactly one cycle; at that edge, if active[winner] is still 1, iack[winner] pulses one cycle, if_q[winner] clears, vector = VEC_BASE + winner*VEC_STRIDE; else (cancelled) no iack, vector = 0.
REQ-030 VECTOR holds vec_valid=1 and vector stable until vec_taken, then -> IDLE next cycle.
REQ-031 Vector arithmetic SHALL be ADR_WIDTH bits, wrapping modulo 2^ADR_WIDTH.
REQ-032 halt_req SHALL set halted; halted SHALL clear, with one-cycle wake pulse, on the cycle after |active goes 1, regardless of ime_q.
REQ-033 halt_req while |active already 1 SHALL not set halted (no halt entered, no wake pulse).
REQ-034 boundary while state != IDLE SHALL be ignored for dispatch.

Reset
REQ-035 areset SHALL force ie_q=0, if_q=0, ime_q=0, EI-pending=0, rr_ptr=0, state=IDLE, vec_valid=0, vector=0, iack=0, halted=0, wake=0, irq edge registers=0.
REQ-036 areset mid-dispatch SHALL abort with no iack and no flag clear.

Verification
REQ-037 Defaults, ie=1F, ime=1, irq[2] edge, boundary -> GRANT, then iack=00100, vector=0x0050, if_q[2]=0.
REQ-038 Fixed mode, flags 10010 pending with ime=1 -> channel 1 (0x0048) first, channel 4 (0x0060) next dispatch.
REQ-039 RR_MODE=1, irq 0 and 3 held re-pending each cycle -> grants alternate 0,3,0,3.
REQ-040 ie_we clearing winner bit during GRANT -> vector=0x0000, no iack, flag retained.
REQ-041 ime_set_dly then boundary -> ime_q still 0; second boundary -> ime_q=1.
REQ-042 ime=0, halt_req, then irq[0] with ie[0]=1 -> wake pulse one cycle later, halted=0, no dispatch.
